// File: rtl/cpu_defs.sv
// cpu_defs: datapath widths and architectural register names shared across
// the GRF, the M/W pipeline register and the hazard unit.
`default_nettype none

package cpu_defs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

`default_nettype wire

// File: rtl/grf_wb_if.sv
// grf_wb_if: W-stage write, D-stage read ports, and write-trace record of the GRF.
`default_nettype none

interface grf_wb_if #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
);

  logic              we_W;
  logic [DATA_W-1:0] a_PC_W;
  logic [ADDR_W-1:0] a_WB_W;
  logic [DATA_W-1:0] v_WB_W;
  logic [ADDR_W-1:0] ra1_D;
  logic [ADDR_W-1:0] ra2_D;
  logic [DATA_W-1:0] rd1_D;
  logic [DATA_W-1:0] rd2_D;
  logic              trace_valid;
  logic [DATA_W-1:0] trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [31:0]       wr_count;

  modport master (
    output we_W, a_PC_W, a_WB_W, v_WB_W, ra1_D, ra2_D,
    input  rd1_D, rd2_D, trace_valid, trace_pc, trace_addr, trace_data, wr_count
  );

  modport slave (
    input  we_W, a_PC_W, a_WB_W, v_WB_W, ra1_D, ra2_D,
    output rd1_D, rd2_D, trace_valid, trace_pc, trace_addr, trace_data, wr_count
  );

endinterface

`default_nettype wire

// File: rtl/grf_wb_read_port.sv
// grf_read_port: one combinational GRF read port with zero/range check and
// optional same-cycle W-stage forwarding.
`default_nettype none

module grf_read_port #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wv,
  input  logic [DATA_W-1:0] regs [NREG],
  output logic [DATA_W-1:0] rd
);

  always_comb begin
    rd = '0;
    // Index 0 and indices beyond the array read as zero, never forwarded.
    if (ra != '0 && int'(ra) < NREG) begin
      if (BYPASS != 0 && we && wa == ra) begin
        rd = wv;
      end else begin
        rd = regs[ra];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/grf_wb.sv
// grf_wb: W-stage general register file with two forwarding D-stage read ports,
// a one-shot write-trace record and a committed-write counter.
`default_nettype none

module grf_wb #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     reset,
  grf_wb_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;
  logic              trace_valid;
  logic [DATA_W-1:0] trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [31:0]       wr_cnt;

  // Writes to index 0 or past the array are silently dropped.
  assign commit = bus.we_W && (bus.a_WB_W != '0) && (int'(bus.a_WB_W) < NREG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[bus.a_WB_W] <= bus.v_WB_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      wr_cnt      <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_pc   <= bus.a_PC_W;
        trace_addr <= bus.a_WB_W;
        trace_data <= bus.v_WB_W;
        wr_cnt     <= wr_cnt + 32'd1;
      end
    end
  end

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_rp1 (
    .ra   (bus.ra1_D),
    .we   (bus.we_W),
    .wa   (bus.a_WB_W),
    .wv   (bus.v_WB_W),
    .regs (regs),
    .rd   (bus.rd1_D)
  );

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_rp2 (
    .ra   (bus.ra2_D),
    .we   (bus.we_W),
    .wa   (bus.a_WB_W),
    .wv   (bus.v_WB_W),
    .regs (regs),
    .rd   (bus.rd2_D)
  );

  assign bus.trace_valid = trace_valid;
  assign bus.trace_pc    = trace_pc;
  assign bus.trace_addr  = trace_addr;
  assign bus.trace_data  = trace_data;
  assign bus.wr_count    = wr_cnt;

endmodule

`default_nettype wire
